// File: rtl/panda_pkg.sv
// Shared types and default sizing for the panda register file.
// Latency: n/a (types only).
// Backpressure: n/a.
package panda_pkg;

    localparam int DefWidth = 32;
    localparam int DefDepth = 32;
    localparam int RegAddrW = $clog2(DefDepth);

    typedef logic [RegAddrW-1:0] reg_addr_t;
    typedef logic [DefWidth-1:0] reg_data_t;

endpackage

// File: rtl/panda_regfile_scoreboard.sv
// Per-register busy tracking: set on issue, cleared by retiring writes, set wins a race.
// Latency: busy_o registered (1 cycle); rbusy_o combinational.
// Backpressure: none; caller stalls on rbusy_o.
module panda_regfile_scoreboard #(
    parameter int Depth    = 32,
    parameter int NumRead  = 2,
    parameter int NumWrite = 1,
    parameter int Bypass   = 1,
    parameter int ZeroReg  = 1,
    parameter int AW       = $clog2(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumRead*AW-1:0]  raddr_i,
    input  logic [NumWrite*AW-1:0] waddr_i,
    input  logic [NumWrite-1:0]    we_i,
    input  logic [NumWrite-1:0]    wclr_i,
    input  logic [AW-1:0]          set_addr_i,
    input  logic                   set_i,
    output logic [NumRead-1:0]     rbusy_o,
    output logic [Depth-1:0]       busy_o
);

    logic [Depth-1:0] busy_q;
    logic [Depth-1:0] busy_d;

    // Clears applied first so a same-cycle set overrides them.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NumWrite; j++) begin
            if (we_i[j] && wclr_i[j]) begin
                busy_d[waddr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (set_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (ZeroReg != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rbusy_o = '0;
        for (int k = 0; k < NumRead; k++) begin
            rbusy_o[k] = busy_q[raddr_i[k*AW +: AW]];
            if (Bypass != 0) begin
                for (int j = 0; j < NumWrite; j++) begin
                    if (we_i[j] && wclr_i[j] && (waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW])) begin
                        rbusy_o[k] = 1'b0;
                    end
                end
            end
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/panda_regfile_mp.sv
// Multi-port register file with integrated busy scoreboard and optional write-to-read bypass.
// Latency: writes 1 cycle; reads combinational (same-cycle when bypassed).
// Backpressure: none; every write/set is accepted every cycle.
module panda_regfile_mp
    import panda_pkg::*;
#(
    parameter int Width    = DefWidth,
    parameter int Depth    = DefDepth,
    parameter int NumRead  = 2,
    parameter int NumWrite = 1,
    parameter int Bypass   = 1,
    parameter int ZeroReg  = 1,
    parameter int AW       = $clog2(Depth)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumRead*AW-1:0]     raddr_i,
    output logic [NumRead*Width-1:0]  rdata_o,
    output logic [NumRead-1:0]        rbusy_o,
    input  logic [NumWrite*AW-1:0]    waddr_i,
    input  logic [NumWrite*Width-1:0] wdata_i,
    input  logic [NumWrite-1:0]       we_i,
    input  logic [NumWrite-1:0]       wclr_i,
    input  logic [AW-1:0]             set_addr_i,
    input  logic                      set_i,
    output logic [Depth-1:0]          busy_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    // Ascending port order: the highest-index port wins an address collision.
    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < NumWrite; j++) begin
            if (we_i[j] && !((ZeroReg != 0) && (waddr_i[j*AW +: AW] == '0))) begin
                mem_d[waddr_i[j*AW +: AW]] = wdata_i[j*Width +: Width];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < Depth; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < NumRead; k++) begin
            rdata_o[k*Width +: Width] = mem_q[raddr_i[k*AW +: AW]];
            if (Bypass != 0) begin
                for (int j = 0; j < NumWrite; j++) begin
                    if (we_i[j] && (waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW])) begin
                        rdata_o[k*Width +: Width] = wdata_i[j*Width +: Width];
                    end
                end
            end
            if ((ZeroReg != 0) && (raddr_i[k*AW +: AW] == '0)) begin
                rdata_o[k*Width +: Width] = '0;
            end
        end
    end

    panda_regfile_scoreboard #(
        .Depth    (Depth),
        .NumRead  (NumRead),
        .NumWrite (NumWrite),
        .Bypass   (Bypass),
        .ZeroReg  (ZeroReg),
        .AW       (AW)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .raddr_i    (raddr_i),
        .waddr_i    (waddr_i),
        .we_i       (we_i),
        .wclr_i     (wclr_i),
        .set_addr_i (set_addr_i),
        .set_i      (set_i),
        .rbusy_o    (rbusy_o),
        .busy_o     (busy_o)
    );

endmodule

// File: tb/tb_panda_regfile_mp.sv
// Bench for panda_regfile_mp: bypassed and non-bypassed instances share one stimulus stream.
module tb_panda_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic          clk;
    logic          rst_n;
    logic [NR*AW-1:0] raddr;
    logic [NW*AW-1:0] waddr;
    logic [NW*W-1:0]  wdata;
    logic [NW-1:0]    we;
    logic [NW-1:0]    wclr;
    logic [AW-1:0]    set_addr;
    logic             set;

    logic [NR*W-1:0] rdata_b, rdata_n;
    logic [NR-1:0]   rbusy_b, rbusy_n;
    logic [D-1:0]    busy_b, busy_n;

    int n_checks;
    int n_fail;

    logic [W-1:0] m_reg [D];
    bit           m_busy [D];

    panda_regfile_mp #(.Width(W), .Depth(D), .NumRead(NR), .NumWrite(NW), .Bypass(1), .ZeroReg(1)) u_byp (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr),
        .set_addr_i(set_addr), .set_i(set), .busy_o(busy_b)
    );

    panda_regfile_mp #(.Width(W), .Depth(D), .NumRead(NR), .NumWrite(NW), .Bypass(0), .ZeroReg(1)) u_nobyp (
        .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .wclr_i(wclr),
        .set_addr_i(set_addr), .set_i(set), .busy_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wa(input int j);
        return int'(waddr[j*AW +: AW]);
    endfunction

    function automatic int ra(input int k);
        return int'(raddr[k*AW +: AW]);
    endfunction

    // Reference read: register 0 reads zero; with bypass the last enabled writer to the address wins.
    function automatic logic [W-1:0] exp_rd(input bit byp, input int a);
        logic [W-1:0] v;
        if (a == 0) return '0;
        v = m_reg[a];
        if (byp) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wa(j) == a) v = wdata[j*W +: W];
            end
        end
        return v;
    endfunction

    function automatic bit exp_rb(input bit byp, input int a);
        bit b;
        b = m_busy[a];
        if (byp) begin
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wclr[j] && wa(j) == a) b = 1'b0;
            end
        end
        return b;
    endfunction

    function automatic logic [D-1:0] exp_busy_vec();
        logic [D-1:0] v;
        for (int r = 0; r < D; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < D; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // One clock edge; the model advances from the inputs held across the edge.
    task automatic tick();
        logic [W-1:0] nreg [D];
        bit           nbusy [D];
        bit           clr;
        @(posedge clk);
        nreg = m_reg;
        for (int j = 0; j < NW; j++) begin
            if (we[j] && wa(j) != 0) nreg[wa(j)] = wdata[j*W +: W];
        end
        for (int r = 0; r < D; r++) begin
            clr = 1'b0;
            for (int j = 0; j < NW; j++) begin
                if (we[j] && wclr[j] && wa(j) == r) clr = 1'b1;
            end
            if (r == 0)                               nbusy[r] = 1'b0;
            else if (set && int'(set_addr) == r)      nbusy[r] = 1'b1;
            else if (clr)                             nbusy[r] = 1'b0;
            else                                      nbusy[r] = m_busy[r];
        end
        m_reg  = nreg;
        m_busy = nbusy;
        #1;
    endtask

    task automatic idle_inputs();
        we = '0; wclr = '0; set = 1'b0; set_addr = '0; waddr = '0; wdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        raddr = {5'd3, 5'd1};
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (rdata_b !== '0 || rdata_n !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h / %h, want 0", rdata_b, rdata_n);
        end
        n_checks++;
        if (busy_b !== '0 || busy_n !== '0 || rbusy_b !== '0 || rbusy_n !== '0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h %h %b %b, want 0", busy_b, busy_n, rbusy_b, rbusy_n);
        end
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_write_read();
        idle_inputs();
        we = 2'b01; waddr[0 +: AW] = 5'd5; wdata[0 +: W] = 32'hDEADBEEF;
        tick();
        idle_inputs();
        raddr = {5'd0, 5'd5};
        #1;
        n_checks++;
        if (rdata_b[0 +: W] !== 32'hDEADBEEF || rdata_n[0 +: W] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_read: got %h / %h, want deadbeef", rdata_b[0 +: W], rdata_n[0 +: W]);
        end
        we = 2'b01; waddr[0 +: AW] = 5'd0; wdata[0 +: W] = 32'h1;
        raddr = {5'd0, 5'd0};
        #1;
        n_checks++;
        if (rdata_b !== '0) begin
            n_fail++;
            $display("FAIL zero_bypass: got %h, want 0", rdata_b);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rdata_b !== '0 || rdata_n !== '0) begin
            n_fail++;
            $display("FAIL zero_reg: got %h / %h, want 0", rdata_b, rdata_n);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 2'b01; waddr[0 +: AW] = 5'd7; wdata[0 +: W] = 32'h1234;
        raddr = {5'd7, 5'd5};
        #1;
        n_checks++;
        if (rdata_b[W +: W] !== 32'h1234) begin
            n_fail++;
            $display("FAIL bypass_on: got %h, want 00001234", rdata_b[W +: W]);
        end
        n_checks++;
        if (rdata_n[W +: W] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_off_old: got %h, want 0", rdata_n[W +: W]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rdata_n[W +: W] !== 32'h1234) begin
            n_fail++;
            $display("FAIL bypass_off_new: got %h, want 00001234", rdata_n[W +: W]);
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        we = 2'b11;
        waddr = {5'd3, 5'd3};
        wdata = {32'hBBBB, 32'hAAAA};
        raddr = {5'd5, 5'd3};
        #1;
        n_checks++;
        if (rdata_b[0 +: W] !== 32'hBBBB) begin
            n_fail++;
            $display("FAIL collision_bypass: got %h, want 0000bbbb", rdata_b[0 +: W]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (rdata_n[0 +: W] !== 32'hBBBB || rdata_b[0 +: W] !== 32'hBBBB) begin
            n_fail++;
            $display("FAIL collision_store: got %h / %h, want 0000bbbb", rdata_b[0 +: W], rdata_n[0 +: W]);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        set = 1'b1; set_addr = 5'd9;
        raddr = {5'd5, 5'd9};
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_not_same_cycle: got %b, want 0", rbusy_b[0]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_b[9] !== 1'b1 || rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_busy: got %b %b %b, want 1 1 1", busy_b[9], rbusy_b[0], rbusy_n[0]);
        end
        we = 2'b10; wclr = 2'b10; waddr[AW +: AW] = 5'd9; wdata[W +: W] = 32'h99;
        #1;
        n_checks++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_bypass: got %b / %b, want 0 / 1", rbusy_b[0], rbusy_n[0]);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_b[9] !== 1'b0 || busy_n[9] !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_busy: got %b / %b, want 0", busy_b[9], busy_n[9]);
        end
        set = 1'b1; set_addr = 5'd9; wclr = 2'b01; waddr[0 +: AW] = 5'd9;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_b[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_without_we: got %b, want 1", busy_b[9]);
        end
    endtask

    task automatic test_set_clear_race();
        idle_inputs();
        set = 1'b1; set_addr = 5'd4;
        we = 2'b01; wclr = 2'b01; waddr[0 +: AW] = 5'd4; wdata[0 +: W] = 32'h5555_0004;
        tick();
        idle_inputs();
        raddr = {5'd0, 5'd4};
        #1;
        n_checks++;
        if (busy_b[4] !== 1'b1 || busy_n[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL race_busy: got %b / %b, want 1", busy_b[4], busy_n[4]);
        end
        n_checks++;
        if (rdata_b[0 +: W] !== 32'h5555_0004) begin
            n_fail++;
            $display("FAIL race_data: got %h, want 55550004", rdata_b[0 +: W]);
        end
        set = 1'b1; set_addr = 5'd0;
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_b[0] !== 1'b0 || rbusy_b[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL set_zero: got %b %b, want 0 0", busy_b[0], rbusy_b[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int j = 0; j < NW; j++) begin
                waddr[j*AW +: AW] = 5'($urandom_range(0, 7));
                wdata[j*W +: W]   = $urandom;
            end
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = 5'($urandom_range(0, 7));
            we       = 2'($urandom);
            wclr     = 2'($urandom);
            set      = 1'($urandom);
            set_addr = 5'($urandom_range(0, 7));
            #1;
            for (int k = 0; k < NR; k++) begin
                n_checks++;
                if (rdata_b[k*W +: W] !== exp_rd(1'b1, ra(k)) || rdata_n[k*W +: W] !== exp_rd(1'b0, ra(k))) begin
                    n_fail++;
                    $display("FAIL rand_rdata%0d cyc %0d: got %h / %h, want %h / %h", k, c,
                             rdata_b[k*W +: W], rdata_n[k*W +: W], exp_rd(1'b1, ra(k)), exp_rd(1'b0, ra(k)));
                end
                n_checks++;
                if (rbusy_b[k] !== exp_rb(1'b1, ra(k)) || rbusy_n[k] !== exp_rb(1'b0, ra(k))) begin
                    n_fail++;
                    $display("FAIL rand_rbusy%0d cyc %0d: got %b / %b, want %b / %b", k, c,
                             rbusy_b[k], rbusy_n[k], exp_rb(1'b1, ra(k)), exp_rb(1'b0, ra(k)));
                end
            end
            tick();
            n_checks++;
            if (busy_b !== exp_busy_vec() || busy_n !== exp_busy_vec()) begin
                n_fail++;
                $display("FAIL rand_busy_vec cyc %0d: got %h / %h, want %h", c, busy_b, busy_n, exp_busy_vec());
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs();
        we = 2'b01; waddr[0 +: AW] = 5'd6; wdata[0 +: W] = 32'hCAFE_F00D;
        set = 1'b1; set_addr = 5'd6;
        tick();
        idle_inputs();
        raddr = {5'd6, 5'd4};
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        n_checks++;
        if (rdata_b !== '0 || rdata_n !== '0) begin
            n_fail++;
            $display("FAIL async_rst_rdata: got %h / %h, want 0", rdata_b, rdata_n);
        end
        n_checks++;
        if (busy_b !== '0 || busy_n !== '0 || rbusy_b !== '0) begin
            n_fail++;
            $display("FAIL async_rst_busy: got %h / %h / %b, want 0", busy_b, busy_n, rbusy_b);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (rdata_b[W +: W] !== exp_rd(1'b1, 6) || rdata_b[W +: W] !== 32'h0) begin
            n_fail++;
            $display("FAIL async_rst_hold: got %h, want 0", rdata_b[W +: W]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_collision();
        test_scoreboard();
        test_set_clear_race();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
